miss_request_issuer: RTL and testbench
======================================

// Module: miss_request_issuer
// PURPOSE
//  Request-side partner of the read miss handler. Accepts one miss address per handshake from
//  tag-check and aligns it to a 64 B line. Pushes the address into the miss-AR FIFO that the
//  read miss handler pops, then issues the line read to memory.
//  Bounds in-flight misses with an outstanding counter, decremented as the handler retires entries.
// PARAMETERS
//  ADDR_W           64  address width (miss-AR FIFO entry width)
//  LINE_OFF_W       6   line-offset bits forced to zero (64 B line = 512-bit data beat)
//  MAX_OUTSTANDING  8   max misses pushed but not yet retired; >=1
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst_n        in   1       synchronous active-low reset
//  valid_i      in   1       tag-check miss request valid
//  ready_o      out  1       issuer can accept a miss
//  addr_i       in   ADDR_W  miss byte address
//  write_en_o   out  1       push to miss-AR FIFO
//  full_i       in   1       miss-AR FIFO full
//  wdata_o      out  ADDR_W  line-aligned address pushed to FIFO
//  mem_valid_o  out  1       memory read request valid
//  mem_ready_i  in   1       memory accepts request
//  mem_addr_o   out  ADDR_W  line-aligned memory read address
//  done_i       in   1       one miss retired by handler (1-cycle pulse per entry)
//  outstanding_o out clog2(MAX_OUTSTANDING+1)  current in-flight count
//  underflow_o  out  1       sticky: done_i seen while count==0
// BEHAVIOUR
//  - Reset (rst_n==0 at clk edge): state=IDLE, count=0, addr_q=0, underflow_o=0.
//    ready_o, write_en_o and mem_valid_o are 0 during reset.
//    A reset mid-operation drops the captured miss; no pending push or request survives.
//  - addr_q = {addr_i[ADDR_W-1:LINE_OFF_W], LINE_OFF_W'b0}, captured on valid_i&&ready_o.
//    wdata_o = mem_addr_o = addr_q at all times.
//  - FSM IDLE -> PUSH -> REQ -> IDLE:
//    IDLE: ready_o = (count < MAX_OUTSTANDING). On valid_i&&ready_o capture, go PUSH.
//          Otherwise stay.
//    PUSH: write_en_o = !full_i (combinational). If !full_i, go REQ; else hold with addr stable.
//    REQ:  mem_valid_o=1 with mem_addr_o stable until mem_ready_i. On mem_ready_i, go IDLE.
//    ready_o=0 outside IDLE. mem_valid_o never deasserts before acceptance.
//  - FIFO push always precedes the memory request, so the handler has the address before data.
//  - Latency: accept at edge N -> write_en_o earliest cycle N+1 -> mem_valid_o earliest N+2.
//    Next accept earliest N+3. Throughput at most 1 miss / 3 cycles.
//  - Counter: +1 on each write_en_o cycle, -1 on done_i. Both in the same cycle: unchanged.
//    done_i with count==0 and no push: count stays 0, underflow_o set until reset.
//    count never exceeds MAX_OUTSTANDING, because ready_o gates capture.
//  - done_i is honoured in every state, including while stalled on full_i or mem_ready_i.
// TESTING
//  1 addr_i=0xAB, full_i=0, mem_ready_i=1 -> write_en_o next cycle wdata_o=0x80;
//    mem_valid_o the cycle after with mem_addr_o=0x80; outstanding_o=1.
//  2 full_i=1 for 3 cycles after accept -> write_en_o=0, state held, ready_o=0.
//    After full_i drops: one push, then the request.
//  3 mem_ready_i=0 for 4 cycles -> mem_valid_o held 4 cycles, mem_addr_o stable, no second push.
//  4 8 misses, no done_i -> outstanding_o=8, ready_o=0.
//    One done_i -> ready_o=1 next cycle and the 9th miss is accepted.
//  5 done_i in the same cycle as write_en_o with count=3 -> count stays 3.
//    done_i at count=0 -> underflow_o=1 and stays set.
//  6 rst_n=0 while in REQ -> next cycle mem_valid_o=0, outstanding_o=0, ready_o=1.

Source files
------------

// File: rtl/miss_request_issuer.sv
// rtl/miss_request_issuer.sv - line-aligned miss push to miss-AR FIFO then memory read issue
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   valid_i / ready_o / addr_i         miss request from tag-check
//   write_en_o / full_i / wdata_o      push into miss-AR FIFO
//   mem_valid_o / mem_ready_i / mem_addr_o  line read request to memory
//   done_i                             one miss retired by the read miss handler
//   outstanding_o                      misses pushed but not yet retired
//   underflow_o                        sticky: retire seen with nothing outstanding
module miss_request_issuer #(
    parameter int ADDR_W          = 64,
    parameter int LINE_OFF_W      = 6,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              write_en_o,
    input  logic              full_i,
    output logic [ADDR_W-1:0] wdata_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              done_i,
    output logic [CNT_W-1:0]  outstanding_o,
    output logic              underflow_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        REQ  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  count_q;
    logic              underflow_q;
    logic              accept;

    // Handshake outputs are held low while reset is asserted so nothing leaks
    // out of a pre-reset state during the reset cycle itself.
    always_comb begin
        state_d     = state_q;
        ready_o     = 1'b0;
        write_en_o  = 1'b0;
        mem_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = rst_n && (count_q < CNT_W'(MAX_OUTSTANDING));
                if (valid_i && ready_o) begin
                    state_d = PUSH;
                end
            end
            PUSH: begin
                write_en_o = rst_n && !full_i;
                if (!full_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_valid_o = rst_n;
                if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept = valid_i && ready_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= {addr_i[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            end
            // A push and a retire in the same cycle cancel out.
            if (write_en_o && !done_i) begin
                count_q <= count_q + 1'b1;
            end else if (done_i && !write_en_o) begin
                if (count_q == '0) begin
                    underflow_q <= 1'b1;
                end else begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    assign wdata_o       = addr_q;
    assign mem_addr_o    = addr_q;
    assign outstanding_o = count_q;
    assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_miss_request_issuer.sv
// tb/tb_miss_request_issuer.sv - self-checking bench for miss_request_issuer
module tb_miss_request_issuer;

    localparam int ADDR_W = 64;
    localparam int MAXO   = 8;
    localparam int CNT_W  = $clog2(MAXO + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              valid_i;
    logic              ready_o;
    logic [ADDR_W-1:0] addr_i;
    logic              write_en_o;
    logic              full_i;
    logic [ADDR_W-1:0] wdata_o;
    logic              mem_valid_o;
    logic              mem_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              done_i;
    logic [CNT_W-1:0]  outstanding_o;
    logic              underflow_o;

    miss_request_issuer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .addr_i        (addr_i),
        .write_en_o    (write_en_o),
        .full_i        (full_i),
        .wdata_o       (wdata_o),
        .mem_valid_o   (mem_valid_o),
        .mem_ready_i   (mem_ready_i),
        .mem_addr_o    (mem_addr_o),
        .done_i        (done_i),
        .outstanding_o (outstanding_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: a miss is either absent, captured-not-pushed, or
    // pushed-awaiting-memory; the counter is plain integer arithmetic.
    bit              m_init    = 0;
    bit              m_pending = 0;
    bit              m_pushed  = 0;
    int              m_count   = 0;
    bit              m_uf      = 0;
    logic [63:0]     m_addr    = 64'h0;
    int              push_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle: apply inputs after negedge, check outputs, clock, update model.
    task automatic tick(input bit r, input bit v, input logic [63:0] a,
                        input bit f, input bit mr, input bit d);
        bit e_ready, e_we, e_mv;
        rst_n = r; valid_i = v; addr_i = a; full_i = f; mem_ready_i = mr; done_i = d;
        #1;
        e_ready = r && !m_pending && (m_count < MAXO);
        e_we    = r && m_pending && !m_pushed && !f;
        e_mv    = r && m_pending && m_pushed;
        chk("ready", 64'(ready_o), 64'(e_ready));
        chk("write_en", 64'(write_en_o), 64'(e_we));
        chk("mem_valid", 64'(mem_valid_o), 64'(e_mv));
        if (m_init) begin
            chk("wdata", wdata_o, m_addr);
            chk("mem_addr", mem_addr_o, m_addr);
            chk("outstanding", 64'(outstanding_o), 64'(m_count));
            chk("underflow", 64'(underflow_o), 64'(m_uf));
        end
        @(posedge clk);
        if (!r) begin
            m_init = 1; m_pending = 0; m_pushed = 0; m_count = 0; m_uf = 0; m_addr = 0;
        end else begin
            if (e_ready && v) begin
                m_pending = 1; m_pushed = 0; m_addr = a & ~64'h3F;
            end else if (e_we) begin
                m_pushed = 1;
            end else if (e_mv && mr) begin
                m_pending = 0;
            end
            if (e_we) push_seen++;
            if (e_we && !d) m_count++;
            else if (d && !e_we) begin
                if (m_count == 0) m_uf = 1;
                else m_count--;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);

        // Single miss, no back-pressure.
        tick(1, 1, 64'hAB, 0, 1, 0);
        #1 chk("t1_push", 64'(write_en_o), 64'h1);
        chk("t1_wdata", wdata_o, 64'h80);
        tick(1, 0, 0, 0, 1, 0);
        #1 chk("t1_req", 64'(mem_valid_o), 64'h1);
        chk("t1_maddr", mem_addr_o, 64'h80);
        tick(1, 0, 0, 0, 1, 0);
        #1 chk("t1_count", 64'(outstanding_o), 64'h1);

        // FIFO full for 3 cycles, then memory stalled for 4.
        tick(1, 1, 64'h1234_5678_9ABC_DEFF, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 1, 64'h0, 1, 0, 0);
        push_seen = 0;
        tick(1, 1, 64'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(1, 1, 64'h0, 0, 0, 0);
        tick(1, 0, 64'h0, 0, 1, 0);
        chk("t23_single_push", 64'(push_seen), 64'h1);
        chk("t23_addr", mem_addr_o, 64'h1234_5678_9ABC_DEC0);

        // Fill to the outstanding limit, retire one, accept again.
        tick(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MAXO; i++) begin
            tick(1, 1, 64'(i * 64 + 5), 0, 1, 0);
            tick(1, 0, 0, 0, 1, 0);
            tick(1, 0, 0, 0, 1, 0);
        end
        #1 chk("t4_full_count", 64'(outstanding_o), 64'd8);
        chk("t4_not_ready", 64'(ready_o), 64'h0);
        tick(1, 1, 64'h5000, 0, 1, 1);
        #1 chk("t4_ready_after_done", 64'(ready_o), 64'h1);
        tick(1, 1, 64'h5040, 0, 1, 0);
        #1 chk("t4_ninth_push", 64'(write_en_o), 64'h1);

        // Push and retire in the same cycle at count 3; underflow from empty.
        tick(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 64'h100, 0, 1, 0);
            tick(1, 0, 0, 0, 1, 0);
            tick(1, 0, 0, 0, 1, 0);
        end
        tick(1, 1, 64'h200, 0, 1, 0);
        tick(1, 0, 0, 0, 1, 1);
        #1 chk("t5_count_same", 64'(outstanding_o), 64'd3);
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        #1 chk("t5_underflow_sticky", 64'(underflow_o), 64'h1);

        // Reset while a request is pending on memory.
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 1, 64'h7777, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        #1 chk("t6_in_req", 64'(mem_valid_o), 64'h1);
        tick(0, 0, 0, 0, 0, 0);
        #1 rst_n = 1;
        #1 chk("t6_mv", 64'(mem_valid_o), 64'h0);
        chk("t6_count", 64'(outstanding_o), 64'h0);
        chk("t6_ready", 64'(ready_o), 64'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 99) != 0),
                 $urandom_range(0, 1),
                 {$urandom, $urandom},
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) < (m_count > 4 ? 4 : 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
